// File: rtl/cntr_sched_pkg.sv
// Shared definitions for the delay-counter arbiter: state encoding, the clog2
// helper and the legal parameter range.
package cntr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NREQ_MIN  = 2;
  localparam int NREQ_MAX  = 16;
  localparam int WIDTH_MIN = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit cfg_valid(input int nreq, input int width);
    return (nreq >= NREQ_MIN) && (nreq <= NREQ_MAX) && (width >= WIDTH_MIN);
  endfunction

endpackage

// File: rtl/cntr_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping around, returned as one-hot, index and valid.
module cntr_rr_pick
  import cntr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [OW-1:0]   ptr_i,
  output logic [NREQ-1:0] oh_o,
  output logic [OW-1:0]   idx_o,
  output logic            vld_o
);

  always_comb begin
    int j;
    j     = 0;
    oh_o  = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr_i is always < NREQ, so a single subtraction wraps the scan.
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!vld_o && req_i[j]) begin
        vld_o   = 1'b1;
        idx_o   = OW'(j);
        oh_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cntr_delay_arbiter.sv
// One shared countdown timer granted round-robin to NREQ requesters; the owner
// holds req while its delay runs down and gets a one-cycle done pulse at the end.
module cntr_delay_arbiter
  import cntr_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 16,
  localparam int OW    = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] delay,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [OW-1:0]         owner,
  output logic [WIDTH-1:0]      remain,
  output logic [1:0]            dbg_state
);

  if (!cfg_valid(NREQ, WIDTH)) begin : g_cfg_err
    $error("cntr_delay_arbiter: NREQ must be 2..16 and WIDTH >= 1");
  end

  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] remain_q, remain_d;

  logic [NREQ-1:0]  pick_oh;
  logic [OW-1:0]    pick_idx;
  logic             pick_vld;
  logic [WIDTH-1:0] pick_delay;
  logic [OW-1:0]    next_ptr;

  cntr_rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .oh_o  (pick_oh),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // One-hot AND-OR select of the winner's delay, sampled only on grant.
  always_comb begin
    pick_delay = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_delay = pick_delay | delay[i*WIDTH +: WIDTH];
    end
  end

  assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d  = ST_RUN;
          owner_d  = pick_idx;
          remain_d = pick_delay;
        end
      end
      ST_RUN: begin
        // A dropped request wins over reaching terminal count.
        if (!req[owner_q]) begin
          state_d  = ST_IDLE;
          ptr_d    = next_ptr;
          remain_d = '0;
        end else if (ena) begin
          if (remain_q == '0) state_d = ST_DONE;
          else                remain_d = remain_q - WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = next_ptr;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q != ST_IDLE) gnt[owner_q]  = 1'b1;
    if (state_q == ST_DONE) done[owner_q] = 1'b1;
    busy      = (state_q != ST_IDLE);
    owner     = owner_q;
    remain    = (state_q == ST_IDLE) ? '0 : remain_q;
    dbg_state = state_q;
  end

endmodule
